// File: rtl/timer_scheduler.sv
// Microsecond timer block with up to eight countdown channels behind a
// simple valid/ready register bus; expiries raise pending bits and irq.
module timer_scheduler #(
    parameter int CLKFREQ  = 1000000,
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    input  logic                mem_write,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    output logic                irq,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [31:0] US_STEP = 32'd1000000;
    localparam logic [31:0] FREQ    = 32'(CLKFREQ);

    typedef enum logic {IDLE, RUN} state_t;

    logic [31:0]         acc_q, acc_d, acc_sum;
    logic                us_tick;
    logic                mem_ready_q;
    logic [31:0]         mem_rdata_q, rdata_d;
    logic                irq_q;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] pend_q, pend_d, w1c;
    logic [CHANNELS-1:0] mask_q;
    logic [CHANNELS-1:0] periodic_q;
    state_t              state_q  [CHANNELS];
    logic [31:0]         period_q [CHANNELS];
    logic [31:0]         count_q  [CHANNELS];

    logic                accept, wr_en, pend_wr, mask_wr;
    logic [27:0]         hi;
    logic [1:0]          lo;
    logic [CHANNELS-1:0] ctrl_wr, period_wr, expire;
    logic                unused_addr;

    assign unused_addr = ^mem_addr[1:0];

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign irq       = irq_q;
    assign tick      = tick_q;

    always_comb begin
        acc_sum = acc_q + US_STEP;
        us_tick = (acc_sum >= FREQ);
        acc_d   = us_tick ? (acc_sum - FREQ) : acc_sum;
    end

    // A request is taken once; the ack cycle blocks re-acceptance.
    assign accept = mem_valid && !mem_ready_q;
    assign wr_en  = accept && mem_write;
    assign hi     = mem_addr[31:4];
    assign lo     = mem_addr[3:2];

    always_comb begin
        rdata_d   = '0;
        pend_wr   = 1'b0;
        mask_wr   = 1'b0;
        ctrl_wr   = '0;
        period_wr = '0;
        if (hi == 28'd0) begin
            case (lo)
                2'd0: rdata_d = {16'h7153, 8'h00, 8'(CHANNELS)};
                2'd1: begin
                    rdata_d = 32'(pend_q);
                    pend_wr = wr_en;
                end
                2'd2: begin
                    rdata_d = 32'(mask_q);
                    mask_wr = wr_en;
                end
                default: rdata_d = '0;
            endcase
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (hi == 28'(i + 1)) begin
                case (lo)
                    2'd0: begin
                        rdata_d    = {30'd0, periodic_q[i], state_q[i] == RUN};
                        ctrl_wr[i] = wr_en;
                    end
                    2'd1: begin
                        rdata_d      = period_q[i];
                        period_wr[i] = wr_en;
                    end
                    2'd2: rdata_d = count_q[i];
                    default: rdata_d = '0;
                endcase
            end
        end
        if (!accept || mem_write) begin
            rdata_d = '0;
        end
    end

    // A control write on the same cycle always beats the countdown.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            expire[i] = (state_q[i] == RUN) && us_tick && !ctrl_wr[i]
                        && (count_q[i] == 32'd1);
        end
        w1c    = pend_wr ? mem_wdata[CHANNELS-1:0] : '0;
        pend_d = (pend_q & ~w1c) | expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            irq_q       <= 1'b0;
            tick_q      <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            periodic_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= IDLE;
                period_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            acc_q       <= acc_d;
            mem_ready_q <= accept;
            mem_rdata_q <= rdata_d;
            irq_q       <= |(pend_q & mask_q);
            tick_q      <= expire;
            pend_q      <= pend_d;
            if (mask_wr) begin
                mask_q <= mem_wdata[CHANNELS-1:0];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (period_wr[i]) begin
                    period_q[i] <= mem_wdata;
                end
                if (ctrl_wr[i]) begin
                    periodic_q[i] <= mem_wdata[1];
                    if (mem_wdata[0] && period_q[i] != 32'd0) begin
                        state_q[i] <= RUN;
                        count_q[i] <= period_q[i];
                    end else begin
                        state_q[i] <= IDLE;
                        count_q[i] <= '0;
                    end
                end else if (state_q[i] == RUN && us_tick) begin
                    if (!expire[i]) begin
                        count_q[i] <= count_q[i] - 32'd1;
                    end else if (periodic_q[i] && period_q[i] != 32'd0) begin
                        count_q[i] <= period_q[i];
                    end else begin
                        count_q[i] <= '0;
                        state_q[i] <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: bus transactions feed a scoreboard
// queue that a negedge monitor drains on every acknowledge.
module tb_timer_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        irq;
    logic [3:0]  tick;

    always #5 clk = ~clk;

    timer_scheduler #(
        .CLKFREQ (4000000),
        .CHANNELS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .irq      (irq),
        .tick     (tick)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] exp;
        string       name;
    } txn_t;

    txn_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   tcnt[4] = '{0, 0, 0, 0};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (tick[i] === 1'b1) tcnt[i]++;
        end
    end

    always @(negedge clk) begin
        txn_t t;
        if (mem_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack expected none");
            end else begin
                t = sbq.pop_front();
                if (t.is_rd) check(t.name, mem_rdata, t.exp);
            end
        end
    end

    task automatic bus(input bit wr, input logic [31:0] addr,
                       input logic [31:0] val, input string name);
        int n;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wr ? val : 32'h0;
        sbq.push_back('{is_rd: !wr, exp: val, name: name});
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (mem_ready !== 1'b1 && n < 20);
        if (mem_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack expected ack", name);
        end
        mem_valid = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
        bus(1'b1, addr, data, "wr");
    endtask

    task automatic rd32(input logic [31:0] addr, input logic [31:0] exp,
                        input string name);
        bus(1'b0, addr, exp, name);
    endtask

    task automatic wait_tick(input int b, input int bound, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick[b] !== 1'b1 && n < bound);
        n_cmp++;
        if (tick[b] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got no tick expected tick[%0d]", name, b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int e;
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", mem_ready, 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_irq", irq, 0);
        check("rst_tick", tick, 0);
        rst = 1'b0;

        // register map after reset, unmapped space
        rd32(32'h00, 32'h7153_0004, "id");
        rd32(32'h01, 32'h7153_0004, "id_lowbits");
        rd32(32'h04, 32'h0, "pend_rst");
        rd32(32'h08, 32'h0, "mask_rst");
        rd32(32'h10, 32'h0, "ctrl0_rst");
        rd32(32'h14, 32'h0, "period0_rst");
        rd32(32'h18, 32'h0, "count0_rst");
        rd32(32'h0C, 32'h0, "unmapped_0c");
        rd32(32'h1C, 32'h0, "unmapped_1c");
        wr32(32'h50, 32'hFFFF_FFFF);
        rd32(32'h50, 32'h0, "unmapped_50");
        rd32(32'h08, 32'h0, "mask_untouched");

        // one-shot channel 0
        wr32(32'h14, 32'd3);
        rd32(32'h14, 32'd3, "period0");
        base = tcnt[0];
        wr32(32'h10, 32'h1);
        rd32(32'h10, 32'h1, "ctrl0_run");
        wait_tick(0, 100, "oneshot_tick");
        @(negedge clk);
        check("tick_width", tick, 0);
        repeat (50) @(negedge clk);
        check("oneshot_count", tcnt[0] - base, 1);
        rd32(32'h10, 32'h0, "ctrl0_done");
        rd32(32'h18, 32'h0, "count0_done");
        rd32(32'h04, 32'h1, "pend_oneshot");
        wr32(32'h04, 32'h1);
        rd32(32'h04, 32'h0, "pend_cleared");

        // periodic channel 1 with irq
        wr32(32'h24, 32'd2);
        wr32(32'h08, 32'h2);
        wr32(32'h20, 32'h3);
        wait_tick(1, 100, "per_tick1");
        e = cyc;
        check("irq_lag", irq, 0);
        @(negedge clk);
        check("irq_set", irq, 1);
        wait_tick(1, 100, "per_tick2");
        check("per_interval", cyc - e, 8);
        wr32(32'h04, 32'h2);
        check("irq_hold", irq, 1);
        repeat (2) @(negedge clk);
        check("irq_clr", irq, 0);
        wr32(32'h20, 32'h0);
        rd32(32'h04, 32'h0, "pend1_clr");
        rd32(32'h28, 32'h0, "count1_off");
        rd32(32'h20, 32'h0, "ctrl1_off");

        // channels 0 and 2 aligned to the same us_tick window
        wr32(32'h44, 32'd1);
        wr32(32'h14, 32'd5);
        wr32(32'h34, 32'd5);
        wr32(32'h40, 32'h1);
        wait_tick(3, 100, "align_t4");
        e = cyc;
        repeat (2) @(negedge clk);
        wr32(32'h10, 32'h1);
        wr32(32'h30, 32'h1);
        wait_tick(0, 100, "dual_tick");
        check("dual_vec", tick, 4'b0101);
        check("dual_latency", cyc - e, 24);
        rd32(32'h04, 32'hD, "pend_dual");
        wr32(32'h04, 32'hF);
        rd32(32'h04, 32'h0, "pend_dual_clr");

        // W1C colliding with expiry
        wr32(32'h14, 32'd1);
        wr32(32'h10, 32'h3);
        wait_tick(0, 100, "align_t5");
        repeat (2) @(negedge clk);
        wr32(32'h04, 32'h1);
        rd32(32'h04, 32'h1, "set_wins");
        wr32(32'h10, 32'h0);
        wr32(32'h04, 32'h1);
        rd32(32'h04, 32'h0, "pend_t5_clr");

        // countdown visibility, disable on the expiry cycle
        wr32(32'h14, 32'd3);
        wr32(32'h40, 32'h1);
        wait_tick(3, 100, "align_t6");
        repeat (2) @(negedge clk);
        wr32(32'h10, 32'h1);
        rd32(32'h18, 32'd3, "cnt_a");
        rd32(32'h18, 32'd3, "cnt_b");
        rd32(32'h18, 32'd2, "cnt_c");
        rd32(32'h18, 32'd2, "cnt_d");
        rd32(32'h18, 32'd1, "cnt_e");
        wr32(32'h10, 32'h0);
        base = tcnt[0];
        repeat (40) @(negedge clk);
        check("no_tick_disable", tcnt[0] - base, 0);
        rd32(32'h18, 32'h0, "count0_off");
        rd32(32'h10, 32'h0, "ctrl0_off");
        rd32(32'h04, 32'h8, "pend_t6");
        wr32(32'h14, 32'd0);
        wr32(32'h10, 32'h1);
        rd32(32'h10, 32'h0, "ctrl0_zero_period");
        rd32(32'h18, 32'h0, "count0_zero_period");
        wr32(32'h04, 32'hF);
        rd32(32'h04, 32'h0, "pend_t6_clr");

        // reset with running channel and held request
        wr32(32'h24, 32'd2);
        wr32(32'h08, 32'h2);
        wr32(32'h20, 32'h3);
        wait_tick(1, 100, "pre_rst_tick");
        @(negedge clk);
        mem_valid = 1'b1;
        mem_write = 1'b0;
        mem_addr  = 32'h08;
        rst       = 1'b1;
        sbq.push_back('{is_rd: 1'b1, exp: 32'h0, name: "rd_after_rst"});
        @(negedge clk);
        check("ready_in_rst", mem_ready, 0);
        check("irq_in_rst", irq, 0);
        check("tick_in_rst", tick, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ack_after_rst", mem_ready, 1);
        mem_valid = 1'b0;
        rd32(32'h20, 32'h0, "ctrl1_rst");
        rd32(32'h24, 32'h0, "period1_rst");
        rd32(32'h28, 32'h0, "count1_rst");
        rd32(32'h04, 32'h0, "pend_rst2");
        rd32(32'h08, 32'h0, "mask_rst2");
        base = tcnt[0] + tcnt[1] + tcnt[2] + tcnt[3];
        repeat (40) @(negedge clk);
        check("no_tick_rst", tcnt[0] + tcnt[1] + tcnt[2] + tcnt[3] - base, 0);
        check("irq_post_rst", irq, 0);

        repeat (4) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
